// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter: fixed-priority grant (store > load > fetch),
// byte-serial sequencing, registered 32-bit result with one-cycle done pulses.
module mem_arbiter #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_SEL     = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [2:0]            ld_size,
  input  logic                  ld_signed,
  output logic                  ld_done,
  input  logic                  st_req,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [2:0]            st_size,
  input  logic [31:0]           st_data,
  output logic                  st_done,
  output logic [31:0]           out_data,
  output logic                  ram_rw,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                state, state_n;
  logic                  owner_ld, owner_ld_n;
  logic [ADDR_WIDTH-1:0] base, base_n;
  logic [2:0]            nb, nb_n;
  logic                  sgn, sgn_n;
  logic [31:0]           wdata, wdata_n;
  logic [2:0]            cnt, cnt_n;
  logic [31:0]           rbuf, rbuf_n;
  logic [31:0]           out_data_n;
  logic                  if_done_n, ld_done_n, st_done_n;
  logic                  ram_rw_n;
  logic [ADDR_WIDTH-1:0] ram_addr_n;
  logic [7:0]            ram_dout_n;

  logic [1:0]  idx;
  logic [31:0] merged, result;
  logic        ext;
  logic        st_ok, ld_ok, if_ok, is_io;

  function automatic logic [2:0] size_bytes(input logic [2:0] sz);
    case (sz)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // A requester whose done is still high is masked so a held req is not re-granted.
  assign st_ok = st_req & ~st_done;
  assign ld_ok = ld_req & ~ld_done & ~clear;
  assign if_ok = if_req & ~if_done & ~clear;
  assign is_io = (base[17:16] == IO_SEL);
  // Capture edge k+2 stores the byte addressed at edge k.
  assign idx   = cnt[1:0] - 2'd2;

  always_comb begin
    merged = rbuf;
    merged[{idx, 3'b000} +: 8] = ram_din;
    ext    = sgn & ((nb == 3'd1) ? merged[7] : merged[15]);
    case (nb)
      3'd1:    result = {{24{ext}}, merged[7:0]};
      3'd2:    result = {{16{ext}}, merged[15:0]};
      default: result = merged;
    endcase
  end

  always_comb begin
    state_n    = state;
    owner_ld_n = owner_ld;
    base_n     = base;
    nb_n       = nb;
    sgn_n      = sgn;
    wdata_n    = wdata;
    cnt_n      = cnt;
    rbuf_n     = rbuf;
    out_data_n = out_data;
    if_done_n  = 1'b0;
    ld_done_n  = 1'b0;
    st_done_n  = 1'b0;
    ram_rw_n   = ram_rw;
    ram_addr_n = ram_addr;
    ram_dout_n = ram_dout;
    case (state)
      IDLE: begin
        if (st_ok) begin
          state_n = WRITE;
          base_n  = st_addr;
          nb_n    = size_bytes(st_size);
          wdata_n = st_data;
          cnt_n   = '0;
        end else if (ld_ok || if_ok) begin
          state_n    = READ;
          owner_ld_n = ld_ok;
          base_n     = ld_ok ? ld_addr : if_addr;
          nb_n       = ld_ok ? size_bytes(ld_size) : 3'd4;
          sgn_n      = ld_ok & ld_signed;
          cnt_n      = 3'd1;
          rbuf_n     = '0;
          ram_rw_n   = 1'b1;
          ram_addr_n = ld_ok ? ld_addr : if_addr;
        end
      end
      READ: begin
        if (clear) begin
          state_n  = IDLE;
          ram_rw_n = 1'b1;
        end else begin
          if (cnt < nb) ram_addr_n = base + ADDR_WIDTH'(cnt);
          if (cnt >= 3'd2) rbuf_n = merged;
          cnt_n = cnt + 3'd1;
          if (cnt == nb + 3'd1) begin
            state_n    = IDLE;
            out_data_n = result;
            ld_done_n  = owner_ld;
            if_done_n  = ~owner_ld;
          end
        end
      end
      WRITE: begin
        if (cnt == nb) begin
          state_n   = IDLE;
          ram_rw_n  = 1'b1;
          st_done_n = 1'b1;
        end else if (is_io && io_buffer_full) begin
          ram_rw_n = 1'b1;
        end else begin
          ram_rw_n   = 1'b0;
          ram_addr_n = base + ADDR_WIDTH'(cnt);
          ram_dout_n = wdata[{cnt[1:0], 3'b000} +: 8];
          cnt_n      = cnt + 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner_ld <= 1'b0;
      base     <= '0;
      nb       <= '0;
      sgn      <= 1'b0;
      wdata    <= '0;
      cnt      <= '0;
      rbuf     <= '0;
      out_data <= '0;
      if_done  <= 1'b0;
      ld_done  <= 1'b0;
      st_done  <= 1'b0;
      ram_rw   <= 1'b1;
      ram_addr <= '0;
      ram_dout <= '0;
    end else if (rdy) begin
      state    <= state_n;
      owner_ld <= owner_ld_n;
      base     <= base_n;
      nb       <= nb_n;
      sgn      <= sgn_n;
      wdata    <= wdata_n;
      cnt      <= cnt_n;
      rbuf     <= rbuf_n;
      out_data <= out_data_n;
      if_done  <= if_done_n;
      ld_done  <= ld_done_n;
      st_done  <= st_done_n;
      ram_rw   <= ram_rw_n;
      ram_addr <= ram_addr_n;
      ram_dout <= ram_dout_n;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the byte-wide RAM port and shares it between three requesters: instruction fetcher (32-bit reads), load unit (1/2/4-byte reads with optional sign extension) and store commit (1/2/4-byte writes).
- Grants by fixed priority, sequences each access byte by byte, and returns one registered 32-bit result with a one-cycle done pulse.
- Honours io_buffer_full for memory-mapped I/O stores.
- Drops speculative fetch/load traffic on a pipeline clear.

Parameters:
- ADDR_WIDTH, 32, width of all addresses.
- IO_SEL, 2'b11, value of addr[17:16] that marks an I/O address.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state and outputs freeze
- clear  in  1  misprediction flush from commit
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse: out_data holds the fetched word
- ld_req  in  1  load request, level, held until ld_done
- ld_addr  in  32  load address
- ld_size  in  3  byte count: 1, 2 or 4
- ld_signed  in  1  sign-extend result
- ld_done  out  1  one-cycle pulse: out_data holds the load result
- st_req  in  1  store request, level, held until st_done
- st_addr  in  32  store address
- st_size  in  3  byte count: 1, 2 or 4
- st_data  in  32  store data, little-endian
- st_done  out  1  one-cycle pulse: store fully written
- out_data  out  32  shared result bus
- ram_rw  out  1  1 = read, 0 = write
- ram_addr  out  32  RAM byte address
- ram_dout  out  8  write byte
- ram_din  in  8  read byte; valid one cycle after its address is presented
- io_buffer_full  in  1  UART buffer full; I/O writes must not issue

Behaviour:
- Reset values: state IDLE; if_done, ld_done, st_done = 0; out_data = 0; ram_rw = 1; ram_addr = 0; ram_dout = 0; byte counter = 0.
- States:
  - IDLE: no access in progress.
  - READ: fetch or load in progress.
  - WRITE: store in progress.
- Arbitration (IDLE only): priority st > ld > if.
  - A requester whose done is high this cycle is masked, so a still-high req is not re-granted.
  - On grant, latch requester id, address, size and data. Later changes to the request inputs have no effect.
- Size rules:
  - Fetch is always 4 bytes.
  - ld_size/st_size values other than 1 or 2 are treated as 4.
- READ, N bytes, grant sampled at edge E0:
  - Edges E0..E(N-1) drive ram_addr = base+k with ram_rw = 1.
  - Edges E2..E(N+1) capture ram_din into byte k-2 of the result.
  - At E(N+1): write the final result to out_data, assert done for one cycle, return to IDLE.
  - The request-to-done latency is therefore N+2 cycles.
- Extension: size 1 extends bit 7 and size 2 extends bit 15 (sign if ld_signed, else zero). The fetch result is never extended.
- WRITE, N bytes:
  - Each cycle drive ram_rw = 0, ram_addr = base+k, ram_dout = st_data[8k+7:8k].
  - After the last byte: ram_rw = 1, st_done pulses, return to IDLE.
  - With no stalls, ram_rw is 0 for exactly N consecutive cycles.
- I/O stall: if the latched store address has addr[17:16] == IO_SEL and io_buffer_full is high, hold ram_rw = 1 and do not advance k. Resume when io_buffer_full drops. No byte is duplicated or skipped.
- I/O loads are issued exactly once per byte; no speculative re-read.
- clear:
  - In READ: abort immediately. Go to IDLE with ram_rw = 1 and no done pulse. out_data keeps its old value.
  - In WRITE: no effect; the store completes and st_done pulses.
  - In IDLE: if_req/ld_req are ignored that cycle; st_req may still be granted.
- Simultaneous events:
  - clear and the final capture edge of a load in the same cycle: the abort wins, no ld_done.
  - done and a new grant are never in the same cycle. The earliest next grant is the edge after done.
- rdy low: hold every register, including the counter and done pulses, i.e. a pulse is stretched until rdy returns.
- rst mid-access: restart from the reset values; the partial write is not completed.

Test Plan:
- Fetch 0x1000, RAM bytes 13 05 00 00 -> if_done 6 cycles after request; out_data = 0x00000513; 4 consecutive read addresses 0x1000..0x1003.
- Signed 1-byte load at 0x20 = 0x80 -> ld_done at latency 3, out_data = 0xFFFFFF80; same with ld_signed = 0 -> 0x00000080.
- if_req, ld_req and st_req asserted in the same cycle -> order: store, then load, then fetch; each done pulses exactly once; none is re-granted while its req stays high through the done cycle.
- 4-byte store 0x11223344 to 0x30000 with io_buffer_full high for 3 cycles after byte 1 -> RAM receives 44, 33, 22, 11 exactly once each; ram_rw is low for 4 cycles total; st_done follows.
- clear asserted during the 3rd cycle of a 4-byte load -> no ld_done, state IDLE next cycle, ram_rw = 1; a pending store is granted on the following edge.
- rst asserted mid-store -> next cycle all outputs equal their reset values and no further bytes are written.
